// File: rtl/free_ptr_queue_mp_pkg.sv
// Shared state encoding for the free-pointer manager.
package free_ptr_queue_mp_pkg;

  typedef enum logic [0:0] {
    FQ_ST_INIT = 1'b0,
    FQ_ST_RUN  = 1'b1
  } fq_state_e;

endpackage

// File: rtl/free_ptr_queue_mp_ptr_fifo.sv
// Synchronous FWFT pointer FIFO: head visible combinationally, pop takes effect at the edge.
// A write while full is accepted only when a pop happens in the same cycle; otherwise it is dropped.
module ptr_fifo_fwft #(
  parameter int W     = 10,
  parameter int DEPTH = 512,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             wr_drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic [AW-1:0]    rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_do, wr_do;

  function automatic logic [AW-1:0] idx_inc(input logic [AW-1:0] i);
    return (i == AW'(DEPTH - 1)) ? '0 : i + AW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign count   = cnt_q;
  assign rd_data = mem_q[rd_idx_q];

  always_comb begin
    rd_do    = rd_en && !empty;
    wr_do    = wr_en && (!full || rd_do);
    wr_drop  = wr_en && !wr_do;
    wr_idx_d = wr_do ? idx_inc(wr_idx_q) : wr_idx_q;
    rd_idx_d = rd_do ? idx_inc(rd_idx_q) : rd_idx_q;
    cnt_d    = cnt_q;
    if (wr_do && !rd_do) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (rd_do && !wr_do) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy and indices define what is valid.
  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem_q[wr_idx_q] <= wr_data;
    end
  end

endmodule

// File: rtl/free_ptr_queue_mp.sv
// Free-pointer manager: self-fills 0..DEPTH-1, serves FWFT allocation, merges N_RET returns via hold regs + RR arbiter.
// Returns reach the FIFO one cycle after handshake; a full hold register deasserts its port's ret_rdy.
module free_ptr_queue_mp
  import free_ptr_queue_mp_pkg::*;
#(
  parameter int PTR_W = 10,
  parameter int DEPTH = 512,
  parameter int N_RET = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               alloc_vld,
  output logic [PTR_W-1:0]   alloc_ptr,
  input  logic               alloc_rd,
  input  logic [N_RET-1:0]   ret_vld,
  input  logic [N_RET*PTR_W-1:0] ret_ptr,
  output logic [N_RET-1:0]   ret_rdy,
  output logic               init_done,
  output logic [PTR_W:0]     free_cnt,
  output logic               err_range,
  output logic               err_ovf,
  output logic               err_udf
);

  localparam int            IW      = (N_RET > 1) ? $clog2(N_RET) : 1;
  localparam logic [PTR_W:0] DEPTH_W = (PTR_W + 1)'(DEPTH);

  fq_state_e        state_q, state_d;
  logic [PTR_W-1:0] init_cnt_q, init_cnt_d;
  logic [N_RET-1:0] hold_full_q, hold_full_d;
  logic [PTR_W-1:0] hold_ptr_q [N_RET];
  logic [PTR_W-1:0] hold_ptr_d [N_RET];
  logic [IW-1:0]    rr_q, rr_d;
  logic             err_range_q, err_range_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_udf_q, err_udf_d;

  logic             arb_vld;
  logic [IW-1:0]    arb_win;
  logic [IW-1:0]    arb_idx;
  logic             fifo_wr, fifo_rd, fifo_full, fifo_empty, fifo_drop;
  logic [PTR_W-1:0] fifo_wdata, fifo_rdata;
  logic             run;

  assign run       = (state_q == FQ_ST_RUN);
  assign init_done = run;
  assign alloc_vld = run && !fifo_empty;
  assign alloc_ptr = alloc_vld ? fifo_rdata : '0;
  assign err_range = err_range_q;
  assign err_ovf   = err_ovf_q;
  assign err_udf   = err_udf_q;
  // Arbitrated writes that the FIFO rejects are the only overflow source.
  assign err_ovf_d = fifo_drop && run;

  // Round-robin search starting at rr_q over the registered hold state.
  always_comb begin
    arb_vld = 1'b0;
    arb_win = '0;
    arb_idx = '0;
    for (int k = 0; k < N_RET; k++) begin
      arb_idx = IW'((int'(rr_q) + k) % N_RET);
      if (!arb_vld && hold_full_q[arb_idx]) begin
        arb_vld = 1'b1;
        arb_win = arb_idx;
      end
    end
    rr_d = rr_q;
    if (arb_vld) begin
      rr_d = (arb_win == IW'(N_RET - 1)) ? '0 : arb_win + IW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    hold_full_d = hold_full_q;
    hold_ptr_d  = hold_ptr_q;
    err_range_d = 1'b0;
    err_udf_d   = 1'b0;
    fifo_wr     = 1'b0;
    fifo_wdata  = init_cnt_q;
    fifo_rd     = 1'b0;
    ret_rdy     = '0;
    case (state_q)
      FQ_ST_INIT: begin
        fifo_wr    = 1'b1;
        init_cnt_d = init_cnt_q + PTR_W'(1);
        if (init_cnt_q == PTR_W'(DEPTH - 1)) begin
          state_d = FQ_ST_RUN;
        end
      end
      default: begin
        ret_rdy   = ~hold_full_q;
        fifo_rd   = alloc_rd;
        err_udf_d = alloc_rd && fifo_empty;
        if (arb_vld) begin
          fifo_wr              = 1'b1;
          fifo_wdata           = hold_ptr_q[arb_win];
          hold_full_d[arb_win] = 1'b0;
        end
        // Load and clear never collide: loading requires the hold to be empty.
        for (int i = 0; i < N_RET; i++) begin
          if (ret_vld[i] && !hold_full_q[i]) begin
            if ({1'b0, ret_ptr[i*PTR_W +: PTR_W]} < DEPTH_W) begin
              hold_full_d[i] = 1'b1;
              hold_ptr_d[i]  = ret_ptr[i*PTR_W +: PTR_W];
            end else begin
              err_range_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FQ_ST_INIT;
      init_cnt_q  <= '0;
      hold_full_q <= '0;
      hold_ptr_q  <= '{default: '0};
      rr_q        <= '0;
      err_range_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_udf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      hold_full_q <= hold_full_d;
      hold_ptr_q  <= hold_ptr_d;
      rr_q        <= rr_d;
      err_range_q <= err_range_d;
      err_ovf_q   <= err_ovf_d;
      err_udf_q   <= err_udf_d;
    end
  end

  ptr_fifo_fwft #(
    .W    (PTR_W),
    .DEPTH(DEPTH),
    .CNT_W(PTR_W + 1)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (fifo_wr),
    .wr_data(fifo_wdata),
    .rd_en  (fifo_rd),
    .rd_data(fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (free_cnt),
    .wr_drop(fifo_drop)
  );

endmodule

// File: tb/tb_free_ptr_queue_mp.sv
// Directed bench for free_ptr_queue_mp (PTR_W=10, DEPTH=512, N_RET=4).
module tb_free_ptr_queue_mp;

  localparam int PW = 10;
  localparam int D  = 512;
  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             alloc_rd = 1'b0;
  logic [NR-1:0]    ret_vld = '0;
  logic [NR*PW-1:0] ret_ptr = '0;
  logic             alloc_vld;
  logic [PW-1:0]    alloc_ptr;
  logic [NR-1:0]    ret_rdy;
  logic             init_done;
  logic [PW:0]      free_cnt;
  logic             err_range, err_ovf, err_udf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  free_ptr_queue_mp #(.PTR_W(PW), .DEPTH(D), .N_RET(NR)) dut (
    .clk(clk), .rst(rst),
    .alloc_vld(alloc_vld), .alloc_ptr(alloc_ptr), .alloc_rd(alloc_rd),
    .ret_vld(ret_vld), .ret_ptr(ret_ptr), .ret_rdy(ret_rdy),
    .init_done(init_done), .free_cnt(free_cnt),
    .err_range(err_range), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ret(input int p, input int v);
    ret_ptr[p*PW +: PW] = PW'(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++; if (alloc_vld !== 1'b0) begin n_err++; $display("FAIL %s alloc_vld: got %0d want 0", tag, alloc_vld); end
    n_vec++; if (alloc_ptr !== '0) begin n_err++; $display("FAIL %s alloc_ptr: got %0d want 0", tag, alloc_ptr); end
    n_vec++; if (ret_rdy !== 4'h0) begin n_err++; $display("FAIL %s ret_rdy: got %b want 0000", tag, ret_rdy); end
    n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL %s init_done: got %0d want 0", tag, init_done); end
    n_vec++; if (free_cnt !== '0) begin n_err++; $display("FAIL %s free_cnt: got %0d want 0", tag, free_cnt); end
    n_vec++; if ({err_range, err_ovf, err_udf} !== 3'b000) begin
      n_err++; $display("FAIL %s errs: got %b want 000", tag, {err_range, err_ovf, err_udf});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; alloc_rd = 1'b0; ret_vld = '0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
  endtask

  // Called right after the last edge with rst high; alloc_rd is pulsed early and must be ignored.
  task automatic test_init();
    int bad = 0;
    for (int k = 1; k <= D - 1; k++) begin
      alloc_rd = (k <= 3);
      step();
      if (init_done !== 1'b0 || alloc_vld !== 1'b0 || ret_rdy !== 4'h0 ||
          err_udf !== 1'b0 || free_cnt !== 11'(k)) bad++;
    end
    alloc_rd = 1'b0;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL init_fill: got %0d bad cycles want 0", bad); end
    step();
    n_vec++; if (init_done !== 1'b1) begin n_err++; $display("FAIL init_done: got %0d want 1", init_done); end
    n_vec++; if (alloc_vld !== 1'b1 || alloc_ptr !== 10'd0) begin
      n_err++; $display("FAIL init_head: got vld=%0d ptr=%0d want vld=1 ptr=0", alloc_vld, alloc_ptr);
    end
    n_vec++; if (free_cnt !== 11'd512) begin n_err++; $display("FAIL init_cnt: got %0d want 512", free_cnt); end
  endtask

  task automatic test_drain();
    int bad = 0;
    for (int i = 0; i < D; i++) begin
      if (alloc_vld !== 1'b1 || alloc_ptr !== PW'(i)) bad++;
      alloc_rd = 1'b1;
      step();
    end
    alloc_rd = 1'b0;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL drain_order: got %0d bad pops want 0", bad); end
    n_vec++; if (alloc_vld !== 1'b0) begin n_err++; $display("FAIL drain_vld: got %0d want 0", alloc_vld); end
    n_vec++; if (free_cnt !== 11'd0) begin n_err++; $display("FAIL drain_cnt: got %0d want 0", free_cnt); end
    n_vec++; if (err_udf !== 1'b0) begin n_err++; $display("FAIL drain_udf: got %0d want 0", err_udf); end
  endtask

  task automatic test_udf();
    alloc_rd = 1'b1;
    step();
    alloc_rd = 1'b0;
    n_vec++; if (err_udf !== 1'b1) begin n_err++; $display("FAIL udf_pulse: got %0d want 1", err_udf); end
    n_vec++; if (free_cnt !== 11'd0) begin n_err++; $display("FAIL udf_cnt: got %0d want 0", free_cnt); end
    step();
    n_vec++; if (err_udf !== 1'b0) begin n_err++; $display("FAIL udf_once: got %0d want 0", err_udf); end
  endtask

  task automatic test_contention();
    int exp_q[11] = '{100, 200, 300, 400, 10, 20, 30, 40, 7, 9, 8};
    int bad = 0;
    set_ret(0, 100); set_ret(1, 200); set_ret(2, 300); set_ret(3, 400);
    n_vec++; if (ret_rdy !== 4'hF) begin n_err++; $display("FAIL cont_rdy_pre: got %b want 1111", ret_rdy); end
    ret_vld = 4'hF;
    step();
    ret_vld = '0;
    n_vec++; if (ret_rdy !== 4'h0) begin n_err++; $display("FAIL cont_rdy_held: got %b want 0000", ret_rdy); end
    step();
    n_vec++; if (alloc_vld !== 1'b1 || alloc_ptr !== 10'd100 || free_cnt !== 11'd1 || ret_rdy !== 4'b0001) begin
      n_err++; $display("FAIL cont_first: got vld=%0d ptr=%0d cnt=%0d rdy=%b want 1/100/1/0001",
                        alloc_vld, alloc_ptr, free_cnt, ret_rdy);
    end
    repeat (3) step();
    n_vec++; if (free_cnt !== 11'd4 || ret_rdy !== 4'hF) begin
      n_err++; $display("FAIL cont_all: got cnt=%0d rdy=%b want 4/1111", free_cnt, ret_rdy);
    end
    set_ret(0, 10); set_ret(1, 20); set_ret(2, 30); set_ret(3, 40);
    ret_vld = 4'hF; step(); ret_vld = '0;
    repeat (4) step();
    set_ret(1, 7);
    ret_vld = 4'b0010; step(); ret_vld = '0;
    step();
    // RR pointer now sits at port 2, so port 3 must beat port 0.
    set_ret(0, 8); set_ret(3, 9);
    ret_vld = 4'b1001; step(); ret_vld = '0;
    repeat (2) step();
    n_vec++; if (free_cnt !== 11'd11) begin n_err++; $display("FAIL cont_cnt: got %0d want 11", free_cnt); end
    for (int i = 0; i < 11; i++) begin
      if (alloc_vld !== 1'b1 || alloc_ptr !== PW'(exp_q[i])) bad++;
      alloc_rd = 1'b1;
      step();
    end
    alloc_rd = 1'b0;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL cont_order: got %0d bad pops want 0", bad); end
  endtask

  task automatic test_backpressure();
    int exp_q[5] = '{51, 52, 50, 53, 54};
    int sent = 0, stalls = 0, p = 52, cyc = 0, bad = 0;
    set_ret(0, 50); set_ret(1, 51); set_ret(2, p);
    ret_vld = 4'b0111;
    step();
    ret_vld = 4'b0100; sent = 1; p = 53; set_ret(2, p);
    while (sent < 3 && cyc < 20) begin
      if (ret_rdy[2]) begin
        step(); sent++; p++; set_ret(2, p);
      end else begin
        stalls++; step();
      end
      cyc++;
    end
    ret_vld = '0;
    step();
    n_vec++; if (sent != 3) begin n_err++; $display("FAIL bp_sent: got %0d want 3", sent); end
    n_vec++; if (stalls != 3) begin n_err++; $display("FAIL bp_stalls: got %0d want 3", stalls); end
    n_vec++; if (free_cnt !== 11'd5 || ret_rdy !== 4'hF) begin
      n_err++; $display("FAIL bp_cnt: got cnt=%0d rdy=%b want 5/1111", free_cnt, ret_rdy);
    end
    for (int i = 0; i < 5; i++) begin
      if (alloc_vld !== 1'b1 || alloc_ptr !== PW'(exp_q[i])) bad++;
      alloc_rd = 1'b1;
      step();
    end
    alloc_rd = 1'b0;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_order: got %0d bad pops want 0", bad); end
  endtask

  task automatic test_range();
    set_ret(0, 600);
    ret_vld = 4'b0001;
    step();
    ret_vld = '0;
    n_vec++; if (err_range !== 1'b1) begin n_err++; $display("FAIL range_pulse: got %0d want 1", err_range); end
    n_vec++; if (ret_rdy !== 4'hF || free_cnt !== 11'd0) begin
      n_err++; $display("FAIL range_state: got rdy=%b cnt=%0d want 1111/0", ret_rdy, free_cnt);
    end
    step();
    n_vec++; if (err_range !== 1'b0 || alloc_vld !== 1'b0 || free_cnt !== 11'd0) begin
      n_err++; $display("FAIL range_after: got err=%0d vld=%0d cnt=%0d want 0/0/0", err_range, alloc_vld, free_cnt);
    end
  endtask

  // Expects a freshly initialised (full) FIFO.
  task automatic test_ovf();
    set_ret(0, 5);
    ret_vld = 4'b0001; step(); ret_vld = '0;
    n_vec++; if (err_ovf !== 1'b0 || ret_rdy !== 4'b1110) begin
      n_err++; $display("FAIL ovf_hold: got err=%0d rdy=%b want 0/1110", err_ovf, ret_rdy);
    end
    step();
    n_vec++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %0d want 1", err_ovf); end
    n_vec++; if (free_cnt !== 11'd512 || ret_rdy !== 4'hF || alloc_ptr !== 10'd0) begin
      n_err++; $display("FAIL ovf_state: got cnt=%0d rdy=%b ptr=%0d want 512/1111/0", free_cnt, ret_rdy, alloc_ptr);
    end
    step();
    n_vec++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_once: got %0d want 0", err_ovf); end
    ret_vld = 4'b0001; step(); ret_vld = '0;
    alloc_rd = 1'b1; step(); alloc_rd = 1'b0;
    n_vec++; if (err_ovf !== 1'b0 || err_udf !== 1'b0 || free_cnt !== 11'd512 || alloc_ptr !== 10'd1) begin
      n_err++; $display("FAIL ovf_pop: got ovf=%0d udf=%0d cnt=%0d ptr=%0d want 0/0/512/1",
                        err_ovf, err_udf, free_cnt, alloc_ptr);
    end
  endtask

  task automatic test_midrun_reset();
    alloc_rd = 1'b1;
    repeat (37) step();
    alloc_rd = 1'b0;
    n_vec++; if (alloc_ptr !== 10'd38 || free_cnt !== 11'd475) begin
      n_err++; $display("FAIL mid_pre: got ptr=%0d cnt=%0d want 38/475", alloc_ptr, free_cnt);
    end
    set_ret(1, 3); set_ret(2, 4);
    ret_vld = 4'b0110; step(); ret_vld = '0;
    n_vec++; if (ret_rdy !== 4'b1001) begin n_err++; $display("FAIL mid_holds: got %b want 1001", ret_rdy); end
    rst = 1'b1;
    step();
    check_reset_outputs("midrst");
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_drain();
    test_udf();
    test_contention();
    test_backpressure();
    test_range();
    test_reset();
    test_init();
    test_ovf();
    test_midrun_reset();
    test_init();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
